// File: rtl/trigger_conditioner_if.sv
// trigger_conditioner_if: raw trigger in, conditioned trigger plus measurement/event outputs.
interface trigger_conditioner_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int TCNT_WIDTH = 16
);
  logic                  gpio_trig_in;
  logic                  trig_out;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  cycles_out;
  logic                  cycles_valid;
  logic                  ovf;
  logic [TCNT_WIDTH-1:0] trig_count;
  logic                  missed;
  modport master (
    output gpio_trig_in,
    input  trig_out, busy, cycles_out, cycles_valid, ovf, trig_count, missed
  );
  modport slave (
    input  gpio_trig_in,
    output trig_out, busy, cycles_out, cycles_valid, ovf, trig_count, missed
  );
endinterface

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: min-width stretch, post-pulse holdoff and duration measurement
// of the GPIO trigger before it reaches the trigger pin.
module trigger_conditioner #(
  parameter int CNT_WIDTH  = 32,
  parameter int MIN_PULSE  = 4,
  parameter int HOLDOFF    = 16,
  parameter int TCNT_WIDTH = 16
) (
  input logic ext_clock,
  input logic reset,
  trigger_conditioner_if.slave tc
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_WIDTH-1:0] MIN_W = CNT_WIDTH'(MIN_PULSE);
  localparam logic [CNT_WIDTH-1:0] MAX_W = '1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACTIVE, STRETCH, HOLD} state_e;
  state_e                state_q, state_d;
  logic                  prev_q, sat_q, sat_d, trig_q, trig_d, cv_q, cv_d;
  logic                  ovf_q, ovf_d, missed_q, missed_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d, cyc_q, cyc_d, width_inc;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                  rise, done, end_p;
  assign rise      = tc.gpio_trig_in & ~prev_q;
  assign done      = width_q >= MIN_W;
  assign width_inc = width_q == MAX_W ? width_q : width_q + 1'b1;
  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prev_q   <= 1'b1;
      sat_q    <= 1'b0;
      trig_q   <= 1'b0;
      cv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
      width_q  <= '0;
      cyc_q    <= '0;
      hcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= tc.gpio_trig_in;
      sat_q    <= sat_d;
      trig_q   <= trig_d;
      cv_q     <= cv_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
      width_q  <= width_d;
      cyc_q    <= cyc_d;
      hcnt_q   <= hcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    sat_d    = sat_q;
    trig_d   = trig_q;
    cv_d     = 1'b0;
    ovf_d    = ovf_q;
    missed_d = 1'b0;
    width_d  = width_q;
    cyc_d    = cyc_q;
    hcnt_d   = hcnt_q;
    tcnt_d   = tcnt_q;
    end_p    = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = ACTIVE;
        trig_d  = 1'b1;
        width_d = CNT_WIDTH'(1);
        sat_d   = 1'b0;
        tcnt_d  = tcnt_q + 1'b1;
      end
      ACTIVE: if (tc.gpio_trig_in) begin
        width_d = width_inc;
        sat_d   = sat_q | (width_q == MAX_W);
      end else if (done) begin
        end_p = 1'b1;
      end else begin
        state_d = STRETCH;
        width_d = width_inc;
      end
      STRETCH: begin
        missed_d = rise;
        end_p    = done;
        width_d  = done ? width_q : width_inc;
      end
      HOLD: begin
        missed_d = rise;
        state_d  = hcnt_q == '0 ? IDLE : HOLD;
        hcnt_d   = hcnt_q == '0 ? hcnt_q : hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Pulse termination is shared by ACTIVE (long input) and STRETCH (short input).
    if (end_p) begin
      trig_d  = 1'b0;
      cyc_d   = width_q;
      ovf_d   = sat_q;
      cv_d    = 1'b1;
      state_d = HOLDOFF == 0 ? IDLE : HOLD;
      hcnt_d  = HOLD_INIT;
    end
  end
  assign tc.trig_out     = trig_q;
  assign tc.busy         = state_q != IDLE;
  assign tc.cycles_out   = cyc_q;
  assign tc.cycles_valid = cv_q;
  assign tc.ovf          = ovf_q;
  assign tc.trig_count   = tcnt_q;
  assign tc.missed       = missed_q;
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner: directed checks on a default instance and a 4-bit-counter instance
// driven by the same trigger input.
module tb_trigger_conditioner;
  logic ext_clock = 1'b0;
  logic reset = 1'b0;
  logic gin = 1'b0;
  int checks = 0, failures = 0;
  int hi_a = 0, hi_b = 0, cv_a = 0, cv_b = 0, ms_a = 0;
  trigger_conditioner_if #(.CNT_WIDTH(32), .TCNT_WIDTH(16)) a ();
  trigger_conditioner_if #(.CNT_WIDTH(4),  .TCNT_WIDTH(16)) b ();
  assign a.gpio_trig_in = gin;
  assign b.gpio_trig_in = gin;
  trigger_conditioner #(.CNT_WIDTH(32), .MIN_PULSE(4), .HOLDOFF(16), .TCNT_WIDTH(16)) dut_a (
    .ext_clock(ext_clock), .reset(reset), .tc(a.slave));
  trigger_conditioner #(.CNT_WIDTH(4), .MIN_PULSE(4), .HOLDOFF(16), .TCNT_WIDTH(16)) dut_b (
    .ext_clock(ext_clock), .reset(reset), .tc(b.slave));
  always #5 ext_clock = ~ext_clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ext_clock);
      #1;
      hi_a += int'(a.trig_out);
      hi_b += int'(b.trig_out);
      cv_a += int'(a.cycles_valid);
      cv_b += int'(b.cycles_valid);
      ms_a += int'(a.missed);
    end
  endtask
  task automatic clr();
    hi_a = 0; hi_b = 0; cv_a = 0; cv_b = 0; ms_a = 0;
  endtask
  initial begin
    tick(3);
    chk("rst_trig_out", 32'(a.trig_out), 0);
    chk("rst_busy", 32'(a.busy), 0);
    chk("rst_cycles_out", a.cycles_out, 0);
    chk("rst_cycles_valid", 32'(a.cycles_valid), 0);
    chk("rst_ovf", 32'(a.ovf), 0);
    chk("rst_trig_count", 32'(a.trig_count), 0);
    chk("rst_missed", 32'(a.missed), 0);
    reset = 1'b1;
    tick(2);
    // basic 10-cycle pulse
    clr();
    gin = 1'b1;
    tick();
    chk("basic_rise_delay1", 32'(a.trig_out), 1);
    chk("basic_busy", 32'(a.busy), 1);
    tick(9);
    gin = 1'b0;
    tick();
    chk("basic_fall", 32'(a.trig_out), 0);
    chk("basic_cv_with_fall", 32'(a.cycles_valid), 1);
    chk("basic_cycles_out", a.cycles_out, 10);
    chk("basic_trig_count", 32'(a.trig_count), 1);
    chk("basic_ovf", 32'(a.ovf), 0);
    chk("basic_high_time", 32'(hi_a), 10);
    tick();
    chk("basic_cv_one_cycle", 32'(a.cycles_valid), 0);
    chk("basic_cv_count", 32'(cv_a), 1);
    tick(20);
    chk("basic_idle_after_hold", 32'(a.busy), 0);
    // 1-cycle input stretched to 4, re-edge during stretch is missed
    clr();
    gin = 1'b1;
    tick();
    gin = 1'b0;
    tick();
    gin = 1'b1;
    tick();
    chk("stretch_missed_strobe", 32'(a.missed), 1);
    gin = 1'b0;
    tick();
    chk("stretch_missed_one_cycle", 32'(a.missed), 0);
    tick();
    chk("stretch_cv", 32'(a.cycles_valid), 1);
    chk("stretch_cycles_out", a.cycles_out, 4);
    chk("stretch_high_time", 32'(hi_a), 4);
    chk("stretch_trig_count", 32'(a.trig_count), 2);
    chk("stretch_missed_count", 32'(ms_a), 1);
    // edge landing on the last HOLD cycle is missed
    tick(15);
    chk("hold_busy_before_last", 32'(a.busy), 1);
    gin = 1'b1;
    tick();
    chk("hold_last_missed", 32'(a.missed), 1);
    chk("hold_last_no_trig", 32'(a.trig_out), 0);
    chk("hold_last_count", 32'(a.trig_count), 2);
    gin = 1'b0;
    tick();
    gin = 1'b1;
    tick();
    chk("hold_after_accept", 32'(a.trig_out), 1);
    chk("hold_after_count", 32'(a.trig_count), 3);
    // edge one cycle after the last HOLD cycle is accepted
    gin = 1'b0;
    clr();
    tick(20);
    chk("hold2_idle", 32'(a.busy), 0);
    gin = 1'b1;
    tick();
    chk("hold2_accept", 32'(a.trig_out), 1);
    chk("hold2_count", 32'(a.trig_count), 4);
    chk("hold2_no_missed", 32'(ms_a), 0);
    gin = 1'b0;
    tick(25);
    // input high while reset releases
    reset = 1'b0;
    gin = 1'b1;
    tick(2);
    reset = 1'b1;
    clr();
    tick(5);
    chk("hiatrst_no_trig", 32'(hi_a), 0);
    chk("hiatrst_busy", 32'(a.busy), 0);
    chk("hiatrst_count", 32'(a.trig_count), 0);
    gin = 1'b0;
    tick();
    gin = 1'b1;
    tick();
    chk("hiatrst_trig", 32'(a.trig_out), 1);
    gin = 1'b0;
    tick(25);
    chk("hiatrst_count_one", 32'(a.trig_count), 1);
    chk("hiatrst_cv_one", 32'(cv_a), 1);
    // saturation on the 4-bit counter instance
    clr();
    gin = 1'b1;
    tick(20);
    gin = 1'b0;
    tick();
    chk("sat_cv", 32'(b.cycles_valid), 1);
    chk("sat_high_time", 32'(hi_b), 20);
    chk("sat_cycles_out", 32'(b.cycles_out), 15);
    chk("sat_ovf", 32'(b.ovf), 1);
    chk("sat_wide_cycles_out", a.cycles_out, 20);
    chk("sat_wide_ovf", 32'(a.ovf), 0);
    tick(20);
    gin = 1'b1;
    tick();
    chk("sat_ovf_held", 32'(b.ovf), 1);
    tick(4);
    gin = 1'b0;
    tick();
    chk("sat_next_cycles_out", 32'(b.cycles_out), 5);
    chk("sat_next_ovf", 32'(b.ovf), 0);
    tick(20);
    // asynchronous reset mid-pulse
    gin = 1'b1;
    tick(3);
    chk("midrst_active", 32'(a.trig_out), 1);
    reset = 1'b0;
    #1;
    chk("midrst_trig_out", 32'(a.trig_out), 0);
    chk("midrst_busy", 32'(a.busy), 0);
    chk("midrst_trig_count", 32'(a.trig_count), 0);
    chk("midrst_cycles_out", a.cycles_out, 0);
    clr();
    tick(2);
    gin = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("midrst_no_cv", 32'(cv_a), 0);
    chk("midrst_idle", 32'(a.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
